// File: rtl/imem_seq_rom.sv
`default_nettype none
// ============================================================================
// Module      : imem_seq_rom
// Description : Instruction memory with power-up clear sweep, loader port and
//               single-cycle registered fetch. It flags misaligned and
//               out-of-range fetches.
//               Optional feature macro IMEM_HALT_DETECT_EN adds a sticky halt
//               indication when HALT_WORD is fetched.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_seq_rom #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFFFFFF,
  parameter logic [DATA_W-1:0] FILL_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              misaligned,
  output logic              out_of_range,
  output logic              halted,
  output logic              busy
);

  localparam int                 c_IDX_W    = $clog2(DEPTH);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_READY = 2'd1,
    S_LOAD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_IDX_W-1:0]  r_clr_idx;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [c_IDX_W-1:0]  w_fetch_idx;
  logic                w_fetch_oor;
  logic [c_IDX_W-1:0]  w_load_idx;
  logic                w_load_oor;
  logic                w_load_mis;
  logic                w_load_wr;
  logic                w_halt_hit;
  logic                w_accept;

  // Word index is the byte address with the two byte-offset bits dropped;
  // any bit above the index makes the address fall outside the array.
  assign w_fetch_idx = addr[c_IDX_W+1:2];
  assign w_fetch_oor = (addr >> (c_IDX_W + 2)) != '0;
  assign w_load_idx  = load_addr[c_IDX_W+1:2];
  assign w_load_oor  = (load_addr >> (c_IDX_W + 2)) != '0;
  assign w_load_mis  = load_addr[1:0] != 2'b00;
  assign w_load_wr   = (r_state == S_LOAD) && load_en && load_we &&
                       !w_load_oor && !w_load_mis;

`ifdef IMEM_HALT_DETECT_EN
  // A clean fetch of the sentinel halts in the same cycle rdata appears.
  assign w_halt_hit = rvalid && !misaligned && !out_of_range &&
                      (rdata == HALT_WORD);
  assign halted     = (r_state == S_HALT) || w_halt_hit;
`else
  logic w_unused_halt_word;
  assign w_unused_halt_word = ^HALT_WORD;
  assign w_halt_hit         = 1'b0;
  assign halted             = 1'b0;
`endif

  // A request issued alongside load_en or alongside a halting rvalid is dropped.
  assign w_accept = (r_state == S_READY) && req && !load_en && !w_halt_hit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and busy indication.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    case (r_state)
      S_CLEAR: begin
        busy = 1'b1;
        if (r_clr_idx == c_LAST_IDX) w_next = S_READY;
      end
      S_READY: begin
        if (load_en)         w_next = S_LOAD;
        else if (w_halt_hit) w_next = S_HALT;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (!load_en) w_next = S_READY;
      end
      S_HALT: begin
        if (load_en) w_next = S_LOAD;
      end
      default: w_next = S_CLEAR;
    endcase
  end

  // Clear-sweep index; wraps back to zero as the sweep completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_idx <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  // Memory array write port: clear sweep has precedence over the loader.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_idx] <= FILL_WORD;
    end else if (w_load_wr) begin
      r_mem[w_load_idx] <= load_data;
    end
  end

  // Registered fetch response; out-of-range fetches never touch the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata        <= '0;
      rvalid       <= 1'b0;
      misaligned   <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      rvalid       <= w_accept;
      misaligned   <= w_accept && (addr[1:0] != 2'b00);
      out_of_range <= w_accept && w_fetch_oor;
      if (w_accept) begin
        rdata <= w_fetch_oor ? FILL_WORD : r_mem[w_fetch_idx];
      end
    end
  end

endmodule
`default_nettype wire
